// File: rtl/mem_pkg.sv
// Shared load/store encodings, the access-unit FSM state type, and the load
// lane-select/extend helper also used by the CPU decoder.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } mau_state_e;

  // Picks the addressed byte/half of a little-endian word and extends it.
  function automatic logic [31:0] lane_extend(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  offset,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = {{24{sgn & b[7]}}, b};
      SZ_H:    r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational byte-lane datapath: builds the store word (sub-word lanes
// replaced into the old word) and the extended load value.
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        signed_i,
  output logic [31:0] store_word_o,
  output logic [31:0] load_val_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       hit;
      logic [7:0] src;

      assign hit = (size_i == SZ_W) ||
                   (size_i == SZ_B && offset_i == 2'(gi)) ||
                   (size_i == SZ_H && offset_i[1] == 1'(gi / 2));

      // Halves feed lanes 0/2 from wdata[7:0] and lanes 1/3 from wdata[15:8].
      assign src = (size_i == SZ_W) ? wdata_i[8*gi +: 8] :
                   (size_i == SZ_H) ? wdata_i[8*(gi % 2) +: 8] :
                                      wdata_i[7:0];

      assign store_word_o[8*gi +: 8] = hit ? src : word_i[8*gi +: 8];
    end
  endgenerate

  assign load_val_o = lane_extend(word_i, size_i, offset_i, signed_i);

endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for the word-addressed DataMemory;
// sub-word stores are done as read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] DataAddr,
  output logic [31:0]       DataIn,
  input  logic [31:0]       DataOut,
  output logic              DMemW,
  output logic              DMemR
);

  mau_state_e        state_q;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              signed_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rd_word_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  logic              req_err;
  logic [31:0]       lane_word;
  logic [31:0]       store_word;
  logic [31:0]       load_val;

  assign req_err = (req_size == SZ_X) ||
                   (req_size == SZ_H && req_addr[0]) ||
                   (req_size == SZ_W && req_addr[1:0] != 2'b00) ||
                   (req_addr[31:ADDR_W+2] != '0);

  // Loads extend straight from DataOut so the result is ready when leaving RD;
  // the RMW merge in WR works from the registered read word.
  assign lane_word = (state_q == ST_RD) ? DataOut : rd_word_q;

  mem_lane_merge u_lane_merge (
    .word_i       (lane_word),
    .wdata_i      (wdata_q),
    .size_i       (size_q),
    .offset_i     (addr_q[1:0]),
    .signed_i     (signed_q),
    .store_word_o (store_word),
    .load_val_o   (load_val)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      rd_word_q    <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q       <= req_addr[ADDR_W+1:0];
            size_q       <= req_size;
            we_q         <= req_we;
            signed_q     <= req_signed;
            wdata_q      <= req_wdata;
            resp_rdata_q <= '0;
            resp_err_q   <= req_err;
            if (req_err)
              state_q <= ST_RESP;
            else if (req_we && req_size == SZ_W)
              state_q <= ST_WR;
            else
              state_q <= ST_RD;
          end
        end
        ST_RD: begin
          rd_word_q <= DataOut;
          if (we_q) begin
            state_q <= ST_WR;
          end else begin
            resp_rdata_q <= load_val;
            state_q      <= ST_RESP;
          end
        end
        ST_WR: begin
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory-side strobes are forced low during reset so an RMW cut short never writes.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP) && !RST;
  assign resp_rdata = resp_valid ? resp_rdata_q : '0;
  assign resp_err   = resp_valid ? resp_err_q : 1'b0;
  assign DMemR      = (state_q == ST_RD) && !RST;
  assign DMemW      = (state_q == ST_WR) && !RST;
  assign DataAddr   = (DMemR || DMemW) ? addr_q[ADDR_W+1:2] : '0;
  assign DataIn     = DMemW ? store_word : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit paired with a 32-word DataMemory model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [4:0]  DataAddr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        DMemW;
  logic        DMemR;

  logic [31:0] mem [0:31];
  int          total = 0;
  int          bad = 0;
  int          wcount = 0;
  int          rcount = 0;

  always #5 CLK = ~CLK;

  mem_access_unit #(.ADDR_W(5)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .DataAddr(DataAddr), .DataIn(DataIn),
    .DataOut(DataOut), .DMemW(DMemW), .DMemR(DMemR)
  );

  assign DataOut = mem[DataAddr];

  always @(posedge CLK) begin
    if (DMemW) mem[DataAddr] <= DataIn;
    if (DMemW) wcount <= wcount + 1;
    if (DMemR) rcount <= rcount + 1;
  end

  // Issues one request from IDLE and waits (bounded) for its response.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
    @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    lat = 99; rd = 'x; er = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    $display("req we=%0b size=%0b signed=%0b addr=%08h wdata=%08h -> lat=%0d rdata=%08h err=%0b",
             we, sz, sg, addr, wd, lat, rd, er);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
        resp_err !== 1'b0 || DMemW !== 1'b0 || DMemR !== 1'b0 ||
        DataAddr !== 5'h0 || DataIn !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%0b rv=%0b rd=%08h err=%0b w=%0b r=%0b a=%0h di=%08h required ready=1 others 0",
               req_ready, resp_valid, resp_rdata, resp_err, DMemW, DMemR, DataAddr, DataIn);
    end
    $display("reset: ready=%0b resp_valid=%0b", req_ready, resp_valid);
  endtask

  task automatic test_byte_load();
    int lat; logic [31:0] rd; logic er;
    mem[3] = 32'h8899AABB;
    do_req(1'b0, SZ_B, 1'b1, 32'h0E, 32'h0, lat, rd, er);
    total++;
    if (lat !== 2 || rd !== 32'hFFFFFF99 || er !== 1'b0) begin
      bad++;
      $display("FAIL lb: lat=%0d rdata=%08h err=%0b required lat=2 rdata=ffffff99 err=0", lat, rd, er);
    end
    do_req(1'b0, SZ_B, 1'b0, 32'h0E, 32'h0, lat, rd, er);
    total++;
    if (lat !== 2 || rd !== 32'h00000099 || er !== 1'b0) begin
      bad++;
      $display("FAIL lbu: lat=%0d rdata=%08h err=%0b required lat=2 rdata=00000099 err=0", lat, rd, er);
    end
  endtask

  task automatic test_half_rmw();
    int lat; logic [31:0] rd; logic er;
    mem[3] = 32'h8899AABB;
    wcount = 0;
    do_req(1'b1, SZ_H, 1'b0, 32'h0C, 32'h00001234, lat, rd, er);
    total++;
    if (lat !== 3 || rd !== 32'h0 || er !== 1'b0) begin
      bad++;
      $display("FAIL sh_resp: lat=%0d rdata=%08h err=%0b required lat=3 rdata=0 err=0", lat, rd, er);
    end
    total++;
    if (wcount !== 1 || mem[3] !== 32'h88991234) begin
      bad++;
      $display("FAIL sh_mem: writes=%0d M3=%08h required writes=1 M3=88991234", wcount, mem[3]);
    end
    do_req(1'b0, SZ_H, 1'b1, 32'h0E, 32'h0, lat, rd, er);
    total++;
    if (lat !== 2 || rd !== 32'hFFFF8899 || er !== 1'b0) begin
      bad++;
      $display("FAIL lh: lat=%0d rdata=%08h err=%0b required lat=2 rdata=ffff8899 err=0", lat, rd, er);
    end
  endtask

  task automatic test_word_store();
    int lat; logic [31:0] rd; logic er;
    mem[31] = 32'h0;
    do_req(1'b1, SZ_W, 1'b0, 32'h7C, 32'hDEADBEEF, lat, rd, er);
    total++;
    if (lat !== 2 || er !== 1'b0 || mem[31] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL sw_top: lat=%0d err=%0b M31=%08h required lat=2 err=0 M31=deadbeef", lat, er, mem[31]);
    end
    wcount = 0;
    do_req(1'b1, SZ_W, 1'b0, 32'h80, 32'h12345678, lat, rd, er);
    total++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || wcount !== 0) begin
      bad++;
      $display("FAIL sw_range: lat=%0d err=%0b rdata=%08h writes=%0d required lat=1 err=1 rdata=0 writes=0",
               lat, er, rd, wcount);
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs = '{32'h06, 32'h03, 32'h00};
    sizes = '{SZ_W, SZ_H, SZ_X};
    mem[0] = 32'hCAFEF00D;
    mem[1] = 32'h0BADBEEF;
    for (int i = 0; i < 3; i++) begin
      rcount = 0;
      do_req(1'b0, sizes[i], 1'b1, addrs[i], 32'h0, lat, rd, er);
      total++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || rcount !== 0) begin
        bad++;
        $display("FAIL err_case%0d: lat=%0d err=%0b rdata=%08h reads=%0d required lat=1 err=1 rdata=0 reads=0",
                 i, lat, er, rd, rcount);
      end
    end
  endtask

  task automatic test_reset_mid_rmw();
    logic seen;
    mem[0] = 32'h11223344;
    wcount = 0;
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B; req_signed = 1'b0;
    req_addr = 32'h01; req_wdata = 32'h55;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if (DMemW !== 1'b1 || DataIn !== 32'h11225544) begin
      bad++;
      $display("FAIL sb_wr_cycle: DMemW=%0b DataIn=%08h required DMemW=1 DataIn=11225544", DMemW, DataIn);
    end
    RST = 1'b1;
    #1;
    total++;
    if (DMemW !== 1'b0) begin
      bad++;
      $display("FAIL rst_gate: DMemW=%0b required 0", DMemW);
    end
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    total++;
    if (req_ready !== 1'b1 || mem[0] !== 32'h11223344 || wcount !== 0) begin
      bad++;
      $display("FAIL rst_rmw: ready=%0b M0=%08h writes=%0d required ready=1 M0=11223344 writes=0",
               req_ready, mem[0], wcount);
    end
    seen = 1'b0;
    repeat (4) begin
      if (resp_valid) seen = 1'b1;
      @(negedge CLK);
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_resp: resp_valid seen=%0b required 0", seen);
    end
    $display("reset mid-RMW: M0=%08h writes=%0d", mem[0], wcount);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_tab [8];
    int accepts, resps, last_acc, bad_gap, bad_data;
    logic ready_now;
    exp_tab = '{32'h01020304, 32'h80000001, 32'hFFFFFFFF, 32'h00000000,
                32'h13579BDF, 32'h2468ACE0, 32'h7FFFFFFF, 32'hA5A55A5A};
    for (int i = 0; i < 8; i++) mem[i] = exp_tab[i];
    accepts = 0; resps = 0; last_acc = -1; bad_gap = 0; bad_data = 0;
    rcount = 0;
    req_we = 1'b0; req_size = SZ_W; req_signed = 1'b0; req_wdata = '0;
    for (int cyc = 0; cyc < 60 && resps < 8; cyc++) begin
      @(negedge CLK);
      if (resp_valid) begin
        if (resp_rdata !== exp_tab[resps] || resp_err !== 1'b0) bad_data++;
        $display("b2b resp %0d: rdata=%08h err=%0b", resps, resp_rdata, resp_err);
        resps++;
      end
      if (accepts < 8) begin
        req_valid = 1'b1;
        req_addr = 32'(accepts * 4);
      end else begin
        req_valid = 1'b0;
      end
      ready_now = req_ready;
      @(posedge CLK);
      if (ready_now && req_valid) begin
        if (last_acc >= 0 && cyc - last_acc != 3) bad_gap++;
        last_acc = cyc;
        accepts++;
      end
    end
    req_valid = 1'b0;
    total++;
    if (resps !== 8 || bad_data !== 0) begin
      bad++;
      $display("FAIL b2b_data: responses=%0d wrong=%0d required responses=8 wrong=0", resps, bad_data);
    end
    total++;
    if (bad_gap !== 0 || accepts !== 8 || rcount !== 8) begin
      bad++;
      $display("FAIL b2b_accept: bad_gaps=%0d accepts=%0d reads=%0d required 0/8/8", bad_gap, accepts, rcount);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    test_reset();
    test_byte_load();
    test_half_rmw();
    test_word_store();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
